// File: rtl/fsram_dp_pkg.sv
// Shared op-code, beat-kind and sequencer definitions for the FSRAM data-process path.
// Used by sram_controller and fsram_data_process.
package fsram_dp_pkg;

    localparam logic [2:0] DP_IDLE    = 3'd0;
    localparam logic [2:0] DP_ZERO3   = 3'd1;
    localparam logic [2:0] DP_PAD_FWD = 3'd2;
    localparam logic [2:0] DP_PAD_BWD = 3'd3;
    localparam logic [2:0] DP_ZERO1   = 3'd4;
    localparam logic [2:0] DP_FRONT   = 3'd5;
    localparam logic [2:0] DP_BACK    = 3'd6;

    typedef enum logic [1:0] {
        BK_ZERO  = 2'd0,
        BK_FRONT = 2'd1,
        BK_BACK  = 2'd2
    } beat_kind_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } dp_state_e;

    // Beats an op writes into the output FIFO; idle and reserved codes write none.
    function automatic logic [1:0] dp_beats(input logic [2:0] op);
        case (op)
            DP_ZERO3:               return 2'd3;
            DP_PAD_FWD, DP_PAD_BWD: return 2'd2;
            DP_ZERO1, DP_FRONT,
            DP_BACK:                return 2'd1;
            default:                return 2'd0;
        endcase
    endfunction

    function automatic beat_kind_e dp_beat_kind(input logic [2:0] op, input logic [1:0] idx);
        case (op)
            DP_PAD_FWD: return (idx == 2'd0) ? BK_ZERO : BK_FRONT;
            DP_PAD_BWD: return (idx == 2'd0) ? BK_BACK : BK_ZERO;
            DP_FRONT:   return BK_FRONT;
            DP_BACK:    return BK_BACK;
            default:    return BK_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/fsram_data_process_dp_out_fifo.sv
// Synchronous output FIFO: register-array storage, combinational head read gated to zero when empty.
module dp_out_fifo #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           din_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [AW-1:0]               rd_q, wr_q;
    logic [AW:0]                 cnt_q;
    logic                        do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign level_o = cnt_q;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = empty_o ? '0 : mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= din_i;
    end

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + 1'b1;
            if (do_pop) rd_q <= rd_q + 1'b1;
            case ({push_i, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/fsram_data_process.sv
// Expands FSRAM read words into per-channel byte beats and queues them for the CCM.
// Optional FSRAM_DP_PAD_VAL_EN: zero beats carry a pad_val sampled at op acceptance.
module fsram_data_process
    import fsram_dp_pkg::*;
#(
    parameter int CHANNEL    = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          op_valid,
    output logic                          op_ready,
    input  logic [2:0]                    op_code,
    input  logic                          sram_sel,
    input  logic [CHANNEL*16-1:0]         QB_1,
    input  logic [CHANNEL*16-1:0]         QB_2,
`ifdef FSRAM_DP_PAD_VAL_EN
    input  logic [7:0]                    pad_val,
`endif
    output logic [CHANNEL*8-1:0]          out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int LW = $clog2(FIFO_DEPTH);
    localparam int SW = LW + 2;

    dp_state_e              state_q;
    logic [1:0]             idx_q;
    logic [2:0]             st_op_q;
    logic                   st_sel_q;
    logic [CHANNEL*16-1:0]  hold_q;

    logic                   emit, accept, load;
    logic [1:0]             rem_after, pending_d;
    logic [SW-1:0]          credit_d;
    logic [CHANNEL*16-1:0]  src;
    beat_kind_e             kind;
    logic [CHANNEL*8-1:0]   beat;
    logic [7:0]             zb;
    logic                   fifo_full, fifo_empty;

`ifdef FSRAM_DP_PAD_VAL_EN
    logic [7:0] pad_q;
    assign zb = pad_q;
`else
    assign zb = 8'h00;
`endif

    assign emit      = (state_q == S_EMIT);
    assign rem_after = emit ? (dp_beats(st_op_q) - 2'd1 - idx_q) : 2'd0;
    assign pending_d = emit ? (rem_after + 2'd1) : 2'd0;
    // Registered level only: a same-cycle pop is ignored, which keeps the credit conservative.
    assign credit_d  = {1'b0, fifo_level} + {{LW{1'b0}}, pending_d} + {{LW{1'b0}}, dp_beats(op_code)};
    assign op_ready  = !rst && (rem_after == 2'd0) && (credit_d <= SW'(FIFO_DEPTH));
    assign accept    = op_valid && op_ready;
    assign load      = accept && (dp_beats(op_code) != 2'd0);

    // First beat reads the live QB; later beats of a multi-beat op come from the hold copy.
    assign src  = (idx_q == 2'd0) ? (st_sel_q ? QB_2 : QB_1) : hold_q;
    assign kind = dp_beat_kind(st_op_q, idx_q);

    for (genvar c = 0; c < CHANNEL; c++) begin : g_ch
        assign beat[8*c +: 8] = (kind == BK_FRONT) ? src[16*c+8 +: 8] :
                                (kind == BK_BACK)  ? src[16*c   +: 8] : zb;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= 2'd0;
            st_op_q  <= DP_IDLE;
            st_sel_q <= 1'b0;
            hold_q   <= '0;
`ifdef FSRAM_DP_PAD_VAL_EN
            pad_q    <= 8'h00;
`endif
        end else begin
            if (emit && idx_q == 2'd0) hold_q <= src;
            if (load) begin
                state_q  <= S_EMIT;
                idx_q    <= 2'd0;
                st_op_q  <= op_code;
                st_sel_q <= sram_sel;
`ifdef FSRAM_DP_PAD_VAL_EN
                pad_q    <= pad_val;
`endif
            end else if (emit) begin
                if (rem_after != 2'd0) idx_q <= idx_q + 2'd1;
                else                   state_q <= S_IDLE;
            end
        end
    end

    dp_out_fifo #(
        .WIDTH (CHANNEL*8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (emit),
        .din_i   (beat),
        .pop_i   (out_ready),
        .dout_o  (out_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    assign out_valid = !fifo_empty;

    always_ff @(posedge clk) begin
        if (!rst) assert (!(emit && fifo_full && !out_ready));
    end

endmodule

// File: tb/tb_fsram_data_process.sv
// Directed self-checking bench for fsram_data_process (default CHANNEL=32, FIFO_DEPTH=8).
module tb_fsram_data_process;
    localparam int CH = 32;
    localparam int DW = CH*8;

    logic            clk = 1'b0;
    logic            rst, op_valid, op_ready, sram_sel, out_valid, out_ready;
    logic [2:0]      op_code;
    logic [CH*16-1:0] QB_1, QB_2;
    logic [DW-1:0]   out_data;
    logic [3:0]      fifo_level;
`ifdef FSRAM_DP_PAD_VAL_EN
    logic [7:0]      pad_val;
`endif

    int checks = 0;
    int failures = 0;
    int acc;
    logic [DW-1:0] q[$];
    logic [DW-1:0] exp3[6];
    logic [DW-1:0] obs;

    always #5 clk = ~clk;

    fsram_data_process dut (
        .clk        (clk),
        .rst        (rst),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_code    (op_code),
        .sram_sel   (sram_sel),
        .QB_1       (QB_1),
        .QB_2       (QB_2),
`ifdef FSRAM_DP_PAD_VAL_EN
        .pad_val    (pad_val),
`endif
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_level (fifo_level)
    );

    // Record every beat the CCM takes, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) q.push_back(out_data);
    end

    function automatic logic [DW-1:0] rep8(input logic [7:0] b);
        return {CH{b}};
    endfunction

    function automatic logic [CH*16-1:0] rep16(input logic [15:0] w);
        return {CH{w}};
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] o, input logic [DW-1:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold a request until accepted; returns at +1 after the accepting edge.
    task automatic issue(input logic [2:0] c, input logic s);
        int n;
        op_valid = 1'b1;
        op_code  = c;
        sram_sel = s;
        #1;
        n = 0;
        while (!op_ready && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        checks++;
        if (n >= 50) begin
            failures++;
            $error("FAIL issue_timeout observed=%0d expected=<50", n);
        end
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        op_code  = 3'd0;
    endtask

    initial begin
        rst = 1'b1; op_valid = 1'b0; op_code = 3'd0; sram_sel = 1'b0;
        QB_1 = '0; QB_2 = '0; out_ready = 1'b0;
`ifdef FSRAM_DP_PAD_VAL_EN
        pad_val = 8'h00;
`endif
        tick(); tick();
        chk("rst_op_ready", DW'(op_ready), DW'(1'b0));
        chk("rst_out_valid", DW'(out_valid), DW'(1'b0));
        chk("rst_level", DW'(fifo_level), DW'(0));
        chk("rst_out_data", out_data, '0);
        rst = 1'b0;

        // op5 then op6 back-to-back from QB_1
        QB_1 = rep16(16'h1234); sram_sel = 1'b0; out_ready = 1'b1;
        op_valid = 1'b1; op_code = 3'd5; #1;
        chk("t1_ready_a", DW'(op_ready), DW'(1'b1));
        tick();
        op_code = 3'd6; #1;
        chk("t1_ready_b", DW'(op_ready), DW'(1'b1));
        tick();
        op_valid = 1'b0; op_code = 3'd0;
        chk("t1_front", out_data, rep8(8'h12));
        tick();
        chk("t1_back_valid", DW'(out_valid), DW'(1'b1));
        chk("t1_back", out_data, rep8(8'h34));
        tick();
        chk("t1_drained", DW'(out_valid), DW'(1'b0));

        // op2 from QB_2; second beat must come from the hold register
        QB_2 = rep16(16'hABCD); sram_sel = 1'b1; op_valid = 1'b1; op_code = 3'd2;
        tick();
        op_valid = 1'b0; #1;
        chk("t2_ready_t1", DW'(op_ready), DW'(1'b0));
        tick();
        QB_2 = '0; #1;
        chk("t2_ready_t2", DW'(op_ready), DW'(1'b1));
        chk("t2_zero", out_data, '0);
        chk("t2_zero_valid", DW'(out_valid), DW'(1'b1));
        tick();
        op_code = 3'd0;
        chk("t2_front_hold", out_data, rep8(8'hAB));
        tick();
        chk("t2_drained", DW'(out_valid), DW'(1'b0));

        // op1, op3, op4 with op0/op7 interleaved
        q.delete();
        QB_1 = rep16(16'h5566);
        issue(3'd1, 1'b0);
        issue(3'd0, 1'b0);
        issue(3'd3, 1'b0);
        issue(3'd7, 1'b0);
        issue(3'd4, 1'b0);
        repeat (8) tick();
        exp3[0] = '0; exp3[1] = '0; exp3[2] = '0;
        exp3[3] = rep8(8'h66); exp3[4] = '0; exp3[5] = '0;
        chk("t3_count", DW'(q.size()), DW'(6));
        for (int k = 0; k < 6; k++) begin
            obs = (k < q.size()) ? q[k] : 'x;
            chk($sformatf("t3_beat%0d", k), obs, exp3[k]);
        end

        // Fill with out_ready low: exactly FIFO_DEPTH single-beat ops accepted
        out_ready = 1'b0; acc = 0;
        op_valid = 1'b1; op_code = 3'd5; sram_sel = 1'b0;
        for (int i = 0; i < 12; i++) begin
            QB_1 = rep16({8'(i+1), 8'h00});
            #1;
            if (op_ready) acc++;
            tick();
        end
        chk("t4_accepts", DW'(acc), DW'(8));
        chk("t4_level", DW'(fifo_level), DW'(8));
        chk("t4_ready_full", DW'(op_ready), DW'(1'b0));
        op_valid = 1'b0;
        q.delete();
        out_ready = 1'b1;
        repeat (10) tick();
        chk("t4_drain_count", DW'(q.size()), DW'(8));
        for (int k = 0; k < 8; k++) begin
            obs = (k < q.size()) ? q[k] : 'x;
            chk($sformatf("t4_drain%0d", k), obs, rep8(8'(k+2)));
        end

        // Reset during second beat of op1 with two beats queued
        out_ready = 1'b0;
        issue(3'd5, 1'b0);
        issue(3'd1, 1'b0);
        tick();
        chk("t5_level_pre", DW'(fifo_level), DW'(2));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_out_valid", DW'(out_valid), DW'(1'b0));
        chk("t5_level", DW'(fifo_level), DW'(0));
        #1;
        chk("t5_op_ready", DW'(op_ready), DW'(1'b1));
        q.delete();
        out_ready = 1'b1;
        repeat (5) tick();
        chk("t5_residual", DW'(q.size()), DW'(0));

`ifdef FSRAM_DP_PAD_VAL_EN
        q.delete();
        pad_val = 8'h80;
        issue(3'd1, 1'b0);
        pad_val = 8'h00;
        repeat (6) tick();
        chk("t6_count", DW'(q.size()), DW'(3));
        for (int k = 0; k < 3; k++) begin
            obs = (k < q.size()) ? q[k] : 'x;
            chk($sformatf("t6_pad%0d", k), obs, rep8(8'h80));
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
